// File: rtl/nmr_acq_pkg.sv
// nmr_acq_pkg: shared state encoding and timing floor constants for the acquisition schedulers
package nmr_acq_pkg;
  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_INIT = 5'b00010;
  localparam logic [4:0] ST_WND  = 5'b00100;
  localparam logic [4:0] ST_GAP  = 5'b01000;
  localparam logic [4:0] ST_FIN  = 5'b10000;
  typedef enum logic [4:0] {
    IDLE = ST_IDLE,
    INIT = ST_INIT,
    WND  = ST_WND,
    GAP  = ST_GAP,
    FIN  = ST_FIN
  } state_t;
  localparam int MIN_PERIOD = 2;
  localparam int MIN_GAP    = 1;
endpackage

// File: rtl/nmr_acq_param_clamp.sv
// nmr_acq_param_clamp: derives effective period P and window length W, keeping at least one low cycle per period
module nmr_acq_param_clamp
  import nmr_acq_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] period,
  input  logic [DW-1:0] wnd_len,
  output logic [DW-1:0] p,
  output logic [DW-1:0] w
);
  logic [DW-1:0] wl;
  // floor the period, floor the window at one cycle, then cap it below the period
  always_comb begin
    p  = period < DW'(MIN_PERIOD) ? DW'(MIN_PERIOD) : period;
    wl = wnd_len == '0 ? DW'(1) : wnd_len;
    w  = wl > p - DW'(MIN_GAP) ? p - DW'(MIN_GAP) : wl;
  end
endmodule

// File: rtl/nmr_acq_echo_sched.sv
// nmr_acq_echo_sched: CPMG echo-train acquisition window scheduler; ACQ_OVERRUN_CHK_EN enables the ACQ_EN overrun monitor
module nmr_acq_echo_sched
  import nmr_acq_pkg::*;
#(
  parameter int DATABUS_WIDTH = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     ADC_CLK,
  input  logic                     RESET_N,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [DATABUS_WIDTH-1:0] INIT_DLY,
  input  logic [DATABUS_WIDTH-1:0] ECHO_PERIOD,
  input  logic [DATABUS_WIDTH-1:0] WND_LEN,
  input  logic [CNT_WIDTH-1:0]     ECHO_CNT,
  input  logic                     ACQ_EN,
  output logic                     ACQ_WND,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [CNT_WIDTH-1:0]     ECHO_IDX,
  output logic                     OVERRUN
);
  state_t state, nxt;
  logic [DATABUS_WIDTH-1:0] per_q, len_q, tmr, tmr_n, p, w;
  logic [CNT_WIDTH-1:0] cnt_q, idx_n;
  logic accept, wnd_n, busy_n, done_n;

  nmr_acq_param_clamp #(.DW(DATABUS_WIDTH)) u_clamp (
    .period  (per_q),
    .wnd_len (len_q),
    .p       (p),
    .w       (w)
  );

  // tmr counts down the initial delay, then counts cycles since the latest window rise
  always_comb begin
    nxt    = state;
    tmr_n  = tmr;
    idx_n  = ECHO_IDX;
    accept = 1'b0;
    unique case (state)
      IDLE: if (START) begin
        accept = 1'b1;
        nxt    = ECHO_CNT == '0 ? FIN : INIT;
        tmr_n  = INIT_DLY;
        idx_n  = '0;
      end
      INIT: if (tmr == '0) begin
        nxt   = WND;
        tmr_n = DATABUS_WIDTH'(1);
        idx_n = ECHO_IDX + CNT_WIDTH'(1);
      end else tmr_n = tmr - DATABUS_WIDTH'(1);
      WND: begin
        tmr_n = tmr + DATABUS_WIDTH'(1);
        if (tmr == w) nxt = ECHO_IDX == cnt_q ? FIN : GAP;
      end
      GAP: if (tmr == p) begin
        nxt   = WND;
        tmr_n = DATABUS_WIDTH'(1);
        idx_n = ECHO_IDX + CNT_WIDTH'(1);
      end else tmr_n = tmr + DATABUS_WIDTH'(1);
      default: nxt = IDLE;
    endcase
    if (ABORT) begin
      nxt    = IDLE;
      accept = 1'b0;
      idx_n  = ECHO_IDX;
    end
    wnd_n  = nxt == WND;
    busy_n = (nxt inside {INIT, WND, GAP}) || (nxt == FIN && state == IDLE);
    done_n = (nxt == FIN && state != IDLE) || (state == FIN && BUSY && !ABORT);
  end

  // state, counters and registered outputs; a zero-count train spends its busy cycle in FIN before DONE
  always_ff @(posedge ADC_CLK) begin
    if (!RESET_N) begin
      state    <= IDLE;
      tmr      <= '0;
      per_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ECHO_IDX <= '0;
      ACQ_WND  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= nxt;
      tmr      <= tmr_n;
      ECHO_IDX <= idx_n;
      ACQ_WND  <= wnd_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
      if (accept) begin
        per_q <= ECHO_PERIOD;
        len_q <= WND_LEN;
        cnt_q <= ECHO_CNT;
      end
    end
  end

`ifdef ACQ_OVERRUN_CHK_EN
  logic acq_en_q;
  // one register stage on the ADC acquisition-active flag
  always_ff @(posedge ADC_CLK) acq_en_q <= ACQ_EN;
  // sticky flag: ADC still acquiring when a later window opens
  always_ff @(posedge ADC_CLK) begin
    if (!RESET_N || accept) OVERRUN <= 1'b0;
    else if (state == GAP && nxt == WND && acq_en_q) OVERRUN <= 1'b1;
  end
`else
  logic unused_acq_en;
  assign unused_acq_en = ACQ_EN;
  assign OVERRUN = 1'b0;
`endif
endmodule

// File: doc/nmr_acq_echo_sched.md
# nmr_acq_echo_sched

Echo-train acquisition scheduler for the NMR receive path. After a single START, it generates a train of ACQ_WND windows, one per CPMG echo, with a programmable initial delay, echo period, window length and echo count. ACQ_WND drives the RX/duplexer enable window generator in the ADC_CLK domain. An optional monitor checks the ADC-side ACQ_EN handshake for window overrun.

## Interface
- DATABUS_WIDTH, 32: width of the delay, period and window-length inputs.
- CNT_WIDTH, 16: width of the echo count and echo index.

- ADC_CLK  in  1  sole clock; all logic on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- START  in  1  level; sampled only in IDLE; a high sample begins a train.
- ABORT  in  1  level; terminates any train on the next edge.
- INIT_DLY  in  DATABUS_WIDTH  cycles from START sample to first window rise, minus 1.
- ECHO_PERIOD  in  DATABUS_WIDTH  cycles between successive window rising edges.
- WND_LEN  in  DATABUS_WIDTH  window high time in cycles.
- ECHO_CNT  in  CNT_WIDTH  number of windows in the train.
- ACQ_EN  in  1  ADC acquisition-active flag, used by the overrun monitor only.
- ACQ_WND  out  1  registered acquisition window to the RX enable generator.
- BUSY  out  1  high from the START sample to train end.
- DONE  out  1  one-cycle pulse at normal completion.
- ECHO_IDX  out  CNT_WIDTH  count of windows started in the current or last train.
- OVERRUN  out  1  sticky overrun flag.

## Operation
- Reset: all outputs are 0 and the state machine is in IDLE.
- START sampled high in IDLE latches INIT_DLY, ECHO_PERIOD, WND_LEN and ECHO_CNT into internal registers. Input changes during a train are ignored.
- Arithmetic is applied to the latched values:
  - P = max(ECHO_PERIOD, 2).
  - W = min(max(WND_LEN, 1), P-1). This guarantees at least one low cycle between windows.
- States:
  - IDLE: on START, clear ECHO_IDX, set BUSY and go to INIT. If the latched ECHO_CNT is 0, go directly to FIN instead.
  - INIT: count down INIT_DLY cycles, then go to WND.
  - WND: ACQ_WND is high for W cycles. ECHO_IDX increments on the rising edge of ACQ_WND. A period counter starts at window rise.
  - GAP: hold ACQ_WND low until the period counter reaches P. Then go to WND if ECHO_IDX < latched count, otherwise go to FIN.
  - FIN: pulse DONE for one cycle, clear BUSY, return to IDLE.
- The last window goes directly from WND to FIN; there is no trailing gap.
- ABORT has priority over everything except reset. On the next edge, ACQ_WND, BUSY and DONE go to 0 and the state becomes IDLE. ECHO_IDX holds its value, and no DONE pulse is issued.
- ABORT and START high together in IDLE: ABORT wins and no train starts.
- START during BUSY is ignored. START held high across FIN→IDLE begins a new train on the first IDLE cycle.
- RESET_N low mid-train: all outputs are 0 on the next edge. This includes OVERRUN.

## Timing
- START is sampled at edge k. ACQ_WND rises at edge k+1+INIT_DLY.
- Window n rises at edge k+1+INIT_DLY+(n-1)·P and is high for exactly W cycles.
- DONE is high for the cycle following the last ACQ_WND fall, and BUSY falls on that same edge.
- ECHO_CNT=0: DONE pulses at edge k+1, and ACQ_WND never rises.
- Throughput: the next START is accepted one cycle after DONE.

## Configuration
- ACQ_OVERRUN_CHK_EN defined:
  - ACQ_EN is registered once.
  - If the registered ACQ_EN is still high at the edge where a non-first ACQ_WND rises, OVERRUN is set.
  - OVERRUN is cleared only by reset or by an accepted START.
  - The train continues unaffected.
- ACQ_OVERRUN_CHK_EN undefined: OVERRUN is tied to 0, and ACQ_EN is unused.

## Structure
- Shared package nmr_acq_pkg holds:
  - one-hot state encoding localparams (IDLE, INIT, WND, GAP, FIN);
  - the minimum-period constant 2;
  - the minimum-gap constant 1.
- One natural sub-module, nmr_acq_param_clamp: a combinational/registered clamp that produces P and W from the latched inputs. It is reused by the TX pulse scheduler.

## Test plan
- INIT_DLY=3, ECHO_PERIOD=10, WND_LEN=4, ECHO_CNT=3, START at edge 0 → ACQ_WND high at edges 4–7, 14–17 and 24–27; DONE at edge 28; ECHO_IDX=3.
- ECHO_CNT=0 → DONE at edge 1, ACQ_WND stays 0, BUSY high for one cycle only.
- WND_LEN=12, ECHO_PERIOD=5, ECHO_CNT=2 → windows of 4 cycles with period 5 (clamped); WND_LEN=0 → 1-cycle windows.
- ABORT asserted during the 2nd window of a 5-echo train → ACQ_WND and BUSY are 0 on the next edge, no DONE, ECHO_IDX=2. A following START restarts cleanly.
- With ACQ_OVERRUN_CHK_EN: ACQ_EN held high through the whole train → OVERRUN sets at the 2nd window rise and stays set until the next START. Without the macro → OVERRUN stays 0.
- RESET_N low for one cycle mid-GAP → all outputs are 0 on the next edge; START is ignored while RESET_N is low.
